data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Clocked, parametrised successor to the 256x8 data RAM. It is a byte-addressable, big-endian data memory with a request/done handshake. It supports byte, halfword, word and doubleword reads and writes, with sign- or zero-extension on narrow reads. A doubleword transfers as two 32-bit beats. It sits in the MEM stage of the pipeline and serves loads and stores.

Parameters:
DEPTH, 256, number of bytes of storage.
ADDR_W, 32, width of Address.
ALIGN_CHECK, 0, when 1 an access whose Address is not a multiple of its size raises Error.

Ports:
Clk  in  1  clock; all state changes on the rising edge.
ResetN  in  1  asynchronous, active-low reset.
Enable  in  1  request strobe; sampled only while Ready=1.
ReadWrite  in  1  1=read, 0=write.
Mode  in  2  access size: 00 byte, 01 halfword, 10 word, 11 doubleword.
Signed  in  1  reads of byte/halfword: 1 sign-extends, 0 zero-extends.
Address  in  ADDR_W  byte address of the most significant byte.
DataIn  in  32  write data, right-justified for byte/halfword.
DataOut  out  32  read data; registered.
Ready  out  1  controller idle; a request can be accepted.
Done  out  1  one-cycle pulse per beat of a completed access.
Beat  out  1  beat index qualifying Done: 0 first word, 1 second word (doubleword only).
Error  out  1  pulses with Done when a request is rejected.

Behaviour:
- Reset (ResetN=0, takes effect immediately): DataOut=0, Ready=1, Done=0, Beat=0, Error=0, FSM=IDLE. Memory contents are not cleared.
- Any in-flight access is aborted by reset. If reset hits after the first word of a doubleword write, that word stays written and the second word is not.
- Accept: a request is accepted on a rising edge with Enable=1 and Ready=1. Enable while Ready=0 is ignored; it is neither queued nor an error.
- Size in bytes: N = 1, 2, 4 or 8 for Mode 00, 01, 10, 11.
- Error condition: Address+N > DEPTH, evaluated at full width with no wrap-around. When ALIGN_CHECK=1, Address mod N != 0 is also an error.
- On an error, no memory or DataOut change occurs; the block goes to RESP with Done=1 and Error=1.
- Byte ordering is big-endian. For a word, Mem[A]=DataIn[31:24], Mem[A+1]=[23:16], Mem[A+2]=[15:8], Mem[A+3]=[7:0]. A halfword uses DataIn[15:8] then DataIn[7:0]. A byte uses DataIn[7:0].
- Narrow reads are right-justified in DataOut. Upper bits are filled with the sign bit when Signed=1, otherwise with 0. Signed is ignored for word and doubleword.
- DataOut holds its previous value during writes.
- FSM states:
  - IDLE: Ready=1. On accept with an error -> RESP (Error). Accept with Mode!=11 -> perform the access at that edge -> RESP. Accept with Mode=11 -> perform word 0 at Address..+3 -> DW1.
  - RESP: Ready=0, Done=1, Beat=0; DataOut valid for reads -> IDLE.
  - DW1: Ready=0, Done=1, Beat=0, DataOut=word 0. For writes, DataIn is sampled at the end of DW1 as word 1 and written to Address+4..+7. For reads, word 1 is loaded at that edge -> DW2.
  - DW2: Ready=0, Done=1, Beat=1, DataOut=word 1 -> IDLE.
- Latency: Done is asserted 1 cycle after accept. Throughput is one single-beat access per 2 cycles, or one doubleword per 3 cycles.
- Done/Error/Beat are registered and low in IDLE.

Test Plan:
- Reset: drive ResetN=0 mid-cycle while IDLE with DataOut nonzero -> DataOut=0, Ready=1, Done=0 immediately, with no clock edge needed.
- Word write 0xDEADBEEF @4, then byte reads @4..7 -> DE, AD, BE, EF. Word read @4 -> DataOut=DEADBEEF with Done exactly 1 cycle after accept, and Ready low for that cycle.
- Extension: half read @6 Signed=1 -> FFFFBEEF; Signed=0 -> 0000BEEF. Byte @4 Signed=1 -> FFFFFFDE; byte @7 Signed=1 -> FFFFFFEF.
- Doubleword: write @8 with 01234567 at accept and 89ABCDEF in the next cycle. Doubleword read @8 -> Done on two consecutive cycles: Beat=0/01234567, then Beat=1/89ABCDEF; Ready=1 on the third cycle. Byte read @11 -> 67.
- Boundaries: word @252 (DEPTH=256) succeeds. Word @253 -> Done=1, Error=1, memory @253..255 unchanged. With ALIGN_CHECK=1, half @5 -> Error, and half @6 succeeds. Enable held during RESP -> exactly one access performed.
- Reset mid-doubleword write @16 (AABBCCDD, 11223344): assert ResetN=0 in DW1 -> word read @16 = AABBCCDD, word read @20 = prior contents, Ready=1.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressable big-endian data memory for the MEM stage.
// Single-beat accesses answer in one cycle; doublewords stream as two 32-bit beats.
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b0
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [1:0]        Mode,
  input  logic              Signed,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              Ready,
  output logic              Done,
  output logic              Beat,
  output logic              Error
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, DW1, DW2} state_t;

  state_t              state, state_nxt;
  logic [7:0]          mem [DEPTH];
  logic [IW-1:0]       base, idx;
  logic                is_read;
  logic [1:0]          eff_mode;
  logic [3:0]          nbytes;
  logic [ADDR_W:0]     end_addr;
  logic                mis, err;
  logic                wr_en, load_dout, err_nxt;
  logic [3:0][7:0]     rb, wd;
  logic [3:0]          we;
  logic [31:0]         rd_data;

  // Range check is done one bit wider than Address so a huge address cannot wrap back in.
  always_comb begin
    nbytes   = 4'd1 << Mode;
    end_addr = {1'b0, Address} + {{(ADDR_W-3){1'b0}}, nbytes};
    mis      = |(Address[2:0] & (nbytes[2:0] - 3'd1));
    err      = (end_addr > DEPTH_W) || (ALIGN_CHECK && mis);
  end

  // IDLE addresses come straight from the request; DW1 works on the latched base's second word.
  assign idx      = (state == IDLE) ? Address[IW-1:0] : base + IW'(4);
  assign eff_mode = (state == IDLE) ? Mode : 2'b10;

  always_comb begin
    for (int k = 0; k < 4; k++) rb[k] = mem[idx + IW'(k)];
    case (eff_mode)
      2'b00:   rd_data = {{24{Signed & rb[0][7]}}, rb[0]};
      2'b01:   rd_data = {{16{Signed & rb[0][7]}}, rb[0], rb[1]};
      default: rd_data = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  // Lane k holds the byte destined for idx+k (most significant byte first).
  always_comb begin
    we = 4'b0000;
    wd = '0;
    case (eff_mode)
      2'b00: begin
        we    = 4'b0001;
        wd[0] = DataIn[7:0];
      end
      2'b01: begin
        we    = 4'b0011;
        wd[0] = DataIn[15:8];
        wd[1] = DataIn[7:0];
      end
      default: begin
        we = 4'b1111;
        wd = {DataIn[7:0], DataIn[15:8], DataIn[23:16], DataIn[31:24]};
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    load_dout = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (Enable) begin
        if (err) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end else begin
          wr_en     = ~ReadWrite;
          load_dout = ReadWrite;
          state_nxt = (Mode == 2'b11) ? DW1 : RESP;
        end
      end
      RESP: state_nxt = IDLE;
      DW1: begin
        wr_en     = ~is_read;
        load_dout = is_read;
        state_nxt = DW2;
      end
      DW2:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      DataOut <= '0;
      Ready   <= 1'b1;
      Done    <= 1'b0;
      Beat    <= 1'b0;
      Error   <= 1'b0;
      base    <= '0;
      is_read <= 1'b0;
    end else begin
      Ready <= (state_nxt == IDLE);
      Done  <= (state_nxt != IDLE);
      Beat  <= (state_nxt == DW2);
      Error <= err_nxt;
      if (load_dout) DataOut <= rd_data;
      if (state == IDLE && Enable) begin
        base    <= Address[IW-1:0];
        is_read <= ReadWrite;
      end
    end
  end

  // Storage survives reset; gating on ResetN keeps a reset edge from committing a write.
  always_ff @(posedge Clk) begin
    if (ResetN && wr_en)
      for (int k = 0; k < 4; k++)
        if (we[k]) mem[idx + IW'(k)] <= wd[k];
  end
endmodule
